// File: rtl/noc_flit_injector.sv
// Transmit-side NoC interface: turns a packet descriptor plus payload words into
// head/body/tail flits on a valid/ack router port, with ack timeout, retry and abort.
module noc_flit_injector #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEST_W      = 4,
    parameter int unsigned LEN_W       = 4,
    parameter int unsigned MAX_LEN     = 8,
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pkt_valid,
    input  logic [DEST_W-1:0]   pkt_dest,
    input  logic [LEN_W-1:0]    pkt_len,
    output logic                pkt_ready,
    input  logic [DATA_W-1:0]   word_data,
    input  logic                word_valid,
    output logic                word_ready,
    output logic                flit_valid,
    output logic [DATA_W+1:0]   flit_data,
    input  logic                router_ack,
    input  logic                router_available,
    output logic                pkt_done,
    output logic                err
);

    localparam int unsigned TO_W = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned RT_W = $clog2(MAX_RETRY + 2);

    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_BODY = 2'b10;
    localparam logic [1:0] TYPE_TAIL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACK,
        ST_BACKOFF,
        ST_FETCH
    } state_t;

    state_t             r_state;
    logic [DATA_W+1:0]  r_flit;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_sent_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic [RT_W-1:0]    r_retry_cnt;
    logic               r_pkt_done;
    logic               r_err;

    logic               w_len_ok;
    logic [DATA_W-1:0]  w_head;
    logic [LEN_W-1:0]   w_sent_nxt;
    logic               w_is_tail;
    logic               w_timeout;

    // Descriptor validation, head payload and per-flit status decode
    always_comb begin
        w_len_ok                     = (pkt_len != '0) && (pkt_len <= LEN_W'(MAX_LEN));
        w_head                       = '0;
        w_head[LEN_W-1:0]            = pkt_len;
        w_head[DEST_W+LEN_W-1:LEN_W] = pkt_dest;
        w_sent_nxt                   = r_sent_cnt + LEN_W'(1);
        w_is_tail                    = (r_flit[DATA_W+1:DATA_W] == TYPE_TAIL);
        w_timeout                    = (r_to_cnt == TO_W'(ACK_TIMEOUT - 1));
    end

    // Handshake outputs are decoded straight from the state
    assign pkt_ready  = (r_state == ST_IDLE) && !reset;
    assign word_ready = (r_state == ST_FETCH);
    assign flit_valid = (r_state == ST_WAIT_ACK) || ((r_state == ST_SEND) && router_available);
    assign flit_data  = r_flit;
    assign pkt_done   = r_pkt_done;
    assign err        = r_err;

    // Packet serializer FSM; the flit register only reloads on entry to SEND from IDLE/FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_flit      <= '0;
            r_len       <= '0;
            r_sent_cnt  <= '0;
            r_to_cnt    <= '0;
            r_retry_cnt <= '0;
            r_pkt_done  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_pkt_done <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (pkt_valid) begin
                        if (w_len_ok) begin
                            r_len       <= pkt_len;
                            r_flit      <= {TYPE_HEAD, w_head};
                            r_sent_cnt  <= '0;
                            r_retry_cnt <= '0;
                            r_state     <= ST_SEND;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (router_available) begin
                        r_to_cnt <= '0;
                        r_state  <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    // An ack in the timeout cycle still completes the flit
                    if (router_ack) begin
                        if (w_is_tail) begin
                            r_pkt_done <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end else if (w_timeout) begin
                        if (r_retry_cnt == RT_W'(MAX_RETRY)) begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_retry_cnt <= r_retry_cnt + RT_W'(1);
                            r_state     <= ST_BACKOFF;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                ST_BACKOFF: begin
                    r_state <= ST_SEND;
                end
                ST_FETCH: begin
                    if (word_valid) begin
                        r_flit      <= {(w_sent_nxt == r_len) ? TYPE_TAIL : TYPE_BODY, word_data};
                        r_sent_cnt  <= w_sent_nxt;
                        r_retry_cnt <= '0;
                        r_state     <= ST_SEND;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_flit_injector.sv
// Randomized bench for noc_flit_injector: a router/core model drives the ports each
// cycle and a transaction-level scoreboard predicts flits, pulses and word usage.
module tb_noc_flit_injector;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned DEST_W      = 4;
    localparam int unsigned LEN_W       = 4;
    localparam int unsigned MAX_LEN     = 8;
    localparam int unsigned ACK_TIMEOUT = 16;
    localparam int unsigned MAX_RETRY   = 3;
    localparam int unsigned FW          = DATA_W + 2;
    localparam int          NEVER       = 1000;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                pkt_valid = 1'b0;
    logic [DEST_W-1:0]   pkt_dest = '0;
    logic [LEN_W-1:0]    pkt_len = '0;
    logic                pkt_ready;
    logic [DATA_W-1:0]   word_data = '0;
    logic                word_valid = 1'b0;
    logic                word_ready;
    logic                flit_valid;
    logic [FW-1:0]       flit_data;
    logic                router_ack = 1'b0;
    logic                router_available = 1'b0;
    logic                pkt_done;
    logic                err;

    always #5 clk = ~clk;

    noc_flit_injector #(
        .DATA_W(DATA_W), .DEST_W(DEST_W), .LEN_W(LEN_W),
        .MAX_LEN(MAX_LEN), .ACK_TIMEOUT(ACK_TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .reset(reset),
        .pkt_valid(pkt_valid), .pkt_dest(pkt_dest), .pkt_len(pkt_len), .pkt_ready(pkt_ready),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .flit_valid(flit_valid), .flit_data(flit_data),
        .router_ack(router_ack), .router_available(router_available),
        .pkt_done(pkt_done), .err(err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard state
    logic [FW-1:0]     exp_q[$];
    logic [DATA_W-1:0] feed_q[$];
    logic [DATA_W-1:0] cur_words[$];
    logic [FW-1:0]     front;
    logic [FW-1:0]     head_f;
    bit  busy = 0, prev_fv = 0, rst_prev = 0;
    bit  err_exp = 0, done_exp = 0, bo_exp = 0;
    bit  err_nx, done_nx, bo_nx;
    int  wcnt = 0, tmo_cnt = 0, delay = 1, rtr_mode = 2, words_taken = 0;

    // Router ack latency for one attempt; NEVER withholds the ack for that attempt
    function automatic int pick_delay(input logic [1:0] ty);
        case (rtr_mode)
            0: begin
                if (tmo_cnt < 2 && $urandom_range(0, 7) == 0) return NEVER;
                case ($urandom_range(0, 4))
                    0: return 1;
                    1: return 2;
                    2: return 3;
                    3: return 4;
                    default: return 16;
                endcase
            end
            1: return NEVER;
            3: return (ty == 2'b10 && tmo_cnt == 0) ? NEVER : 1;
            4: return (ty == 2'b01) ? 1 : NEVER;
            default: return 1;
        endcase
    endfunction

    // Per-cycle: drive router/core inputs, sample outputs, advance the scoreboard
    always @(negedge clk) begin
        err_nx = 0;
        done_nx = 0;
        bo_nx = 0;
        if (rtr_mode == 5)                       router_available = 1'b0;
        else if (rtr_mode == 0 || rtr_mode == 3) router_available = ($urandom_range(0, 3) != 0);
        else                                     router_available = 1'b1;
        // A flit seen last cycle and still presented means the DUT is waiting for ack
        if (prev_fv) router_ack = (wcnt + 1 >= delay);
        else         router_ack = ($urandom_range(0, 3) == 0);
        if (feed_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            word_valid = 1'b1;
            word_data  = feed_q[0];
        end else begin
            word_valid = 1'b0;
            word_data  = $urandom;
        end
        #1;
        front = (exp_q.size() > 0) ? exp_q[0] : '0;
        check("pkt_ready", pkt_ready, !reset && !busy);
        check("err", err, err_exp);
        check("pkt_done", pkt_done, done_exp);
        if (bo_exp) check("backoff_fv", flit_valid, 1'b0);
        if (rst_prev) begin
            check("rst_flit_valid", flit_valid, 1'b0);
            check("rst_word_ready", word_ready, 1'b0);
            check("rst_flit_data", flit_data, '0);
        end
        if (flit_valid) begin
            if (exp_q.size() == 0) check("spurious_flit", flit_valid, 1'b0);
            else                   check("flit_data", flit_data, front);
        end
        if (reset) begin
            exp_q.delete();
            feed_q.delete();
            busy = 0;
            wcnt = 0;
            tmo_cnt = 0;
        end else begin
            if (pkt_valid && pkt_ready) begin
                if (pkt_len >= 1 && pkt_len <= MAX_LEN) begin
                    head_f = '0;
                    head_f[LEN_W-1:0] = pkt_len;
                    head_f[DEST_W+LEN_W-1:LEN_W] = pkt_dest;
                    head_f[FW-1 -: 2] = 2'b01;
                    exp_q.push_back(head_f);
                    for (int i = 0; i < int'(pkt_len); i++)
                        exp_q.push_back({(i == int'(pkt_len) - 1) ? 2'b11 : 2'b10, cur_words[i]});
                    feed_q = cur_words;
                    busy = 1;
                    tmo_cnt = 0;
                    wcnt = 0;
                end else begin
                    err_nx = 1;
                end
            end
            if (word_valid && word_ready) begin
                void'(feed_q.pop_front());
                words_taken++;
            end
            if (flit_valid && prev_fv) begin
                if (router_ack) begin
                    if (front[FW-1 -: 2] == 2'b11) begin
                        done_nx = 1;
                        busy = 0;
                    end
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    wcnt = 0;
                    tmo_cnt = 0;
                end else begin
                    wcnt++;
                    if (wcnt == ACK_TIMEOUT) begin
                        wcnt = 0;
                        tmo_cnt++;
                        if (tmo_cnt == MAX_RETRY + 1) begin
                            err_nx = 1;
                            busy = 0;
                            exp_q.delete();
                            feed_q.delete();
                        end else begin
                            bo_nx = 1;
                        end
                    end
                end
            end
            if (flit_valid && !prev_fv) delay = pick_delay(front[FW-1 -: 2]);
        end
        prev_fv  = flit_valid && !reset;
        rst_prev = reset;
        err_exp  = err_nx;
        done_exp = done_nx;
        bo_exp   = bo_nx;
    end

    // Present one descriptor (DUT known idle) and leave pkt_valid low afterwards
    task automatic start_pkt(input int dest, input int len, input int mode, output int base);
        cur_words.delete();
        for (int i = 0; i < len; i++) cur_words.push_back($urandom);
        rtr_mode  = mode;
        base      = words_taken;
        pkt_valid = 1'b1;
        pkt_dest  = DEST_W'(dest);
        pkt_len   = LEN_W'(len);
        @(negedge clk);
        pkt_valid = 1'b0;
        pkt_dest  = DEST_W'($urandom);
        pkt_len   = LEN_W'($urandom);
    endtask

    task automatic finish_pkt(input int base, input int exp_words);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("pkt_complete_in_time", n < 3000, 1'b1);
        check("words_taken", 64'(words_taken - base), 64'(exp_words));
    endtask

    task automatic send_pkt(input int dest, input int len, input int mode);
        int base;
        int exp_words;
        start_pkt(dest, len, mode, base);
        exp_words = (mode == 1 || len < 1 || len > int'(MAX_LEN)) ? 0 : len;
        finish_pkt(base, exp_words);
    endtask

    initial begin
        int base;
        int n;
        int len;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single packet, quick acks
        send_pkt(5, 3, 2);
        // Back-to-back short packet straight from the pkt_done cycle
        send_pkt(1, 1, 2);
        // Router backpressure for 4 cycles while the head waits in SEND
        start_pkt(9, 2, 5, base);
        for (int k = 0; k < 4; k++) begin
            #2;
            check("bp_flit_valid", flit_valid, 1'b0);
            if (k == 3) rtr_mode = 2;
            @(negedge clk);
        end
        finish_pkt(base, 2);
        // First attempt of every body flit times out, then succeeds
        send_pkt(6, 4, 3);
        // No ack at all: four head attempts then err, no words consumed
        send_pkt(12, 3, 1);
        // Bad lengths
        send_pkt(2, 0, 2);
        send_pkt(7, 9, 2);
        // Reset while the second flit waits for ack
        start_pkt(3, 3, 4, base);
        n = 0;
        while (words_taken == base && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("second_flit_loaded", n < 500, 1'b1);
        repeat (4) @(negedge clk);
        #2;
        check("mid_pkt_waiting", flit_valid, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_pkt(11, 1, 2);

        // Randomized traffic with random availability, ack latency and occasional timeouts
        for (int p = 0; p < 30; p++) begin
            if ($urandom_range(0, 9) == 0)
                len = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(9, 15));
            else
                len = int'($urandom_range(1, MAX_LEN));
            send_pkt(int'($urandom_range(0, 15)), len, 0);
        end

        repeat (3) @(negedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/noc_flit_injector.md
# noc_flit_injector

Transmit-side network interface: accepts a packet descriptor and payload words from the local core, serializes them into head/body/tail flits and drives them into the router input port using the router's valid/ack handshake. It retransmits on acknowledge timeout and aborts after a bounded number of retries. It sits between the core's packet port and a router `RECEIVE` port.

## Interface
- `DATA_W`, 32: payload word width; must be ≥ `DEST_W + LEN_W`.
- `DEST_W`, 4: destination address width.
- `LEN_W`, 4: payload length field width.
- `MAX_LEN`, 8: maximum payload words per packet; must be < 2^`LEN_W`.
- `ACK_TIMEOUT`, 16: cycles in `WAIT_ACK` without `router_ack` before a retry.
- `MAX_RETRY`, 3: retransmissions allowed per flit before abort.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `pkt_valid` in 1: core offers a packet descriptor.
- `pkt_dest` in `DEST_W`: destination.
- `pkt_len` in `LEN_W`: payload word count.
- `pkt_ready` out 1: descriptor accepted when `pkt_valid && pkt_ready`.
- `word_data` in `DATA_W`: payload word.
- `word_valid` in 1: payload word available.
- `word_ready` out 1: payload word consumed when `word_valid && word_ready`.
- `flit_valid` out 1: flit presented to the router.
- `flit_data` out `DATA_W+2`: `{type[1:0], payload}`; type 01 = head, 10 = body, 11 = tail.
- `router_ack` in 1: router accepted the current flit.
- `router_available` in 1: router can take a new flit.
- `pkt_done` out 1: one-cycle pulse after the tail flit is acked.
- `err` out 1: one-cycle pulse on bad length or retry exhaustion.

## Operation
- **States:** `IDLE`, `SEND`, `WAIT_ACK`, `BACKOFF`, `FETCH`.
- **`IDLE`**
  - `pkt_ready` = 1.
  - On `pkt_valid`:
    - If 1 ≤ `pkt_len` ≤ `MAX_LEN`: latch dest and len, load the head flit, clear `sent_cnt` and `retry_cnt`, go to `SEND`.
    - Otherwise: drop the descriptor, pulse `err`, stay in `IDLE`.
- **Head flit:** type 01; payload[`LEN_W-1:0`] = len; payload[`DEST_W+LEN_W-1:LEN_W`] = dest; upper bits 0.
- **`SEND`**
  - `flit_valid` = `router_available`.
  - If `router_available`: clear the timeout counter and go to `WAIT_ACK`.
  - Otherwise: stay in `SEND`.
- **`WAIT_ACK`**
  - `flit_valid` = 1; `flit_data` is held stable.
  - `router_ack` is sampled only in this state.
  - On ack:
    - If the flit is the tail: pulse `pkt_done` and go to `IDLE`.
    - Otherwise: go to `FETCH`.
  - On no ack, the timeout counter increments. When it reaches `ACK_TIMEOUT-1` with no ack:
    - If `retry_cnt == MAX_RETRY`: pulse `err` and go to `IDLE` (abort; remaining payload words are not consumed).
    - Otherwise: increment `retry_cnt` and go to `BACKOFF`.
  - Ack and timeout in the same cycle: ack wins.
- **`BACKOFF`:** `flit_valid` = 0 for exactly one cycle, then `SEND` with the same flit.
- **`FETCH`**
  - `word_ready` = 1.
  - On `word_valid`: load the flit, increment `sent_cnt`, clear `retry_cnt`, go to `SEND`.
  - Flit type is 11 if the incremented `sent_cnt` equals len, otherwise 10.
- **Counter reset on new flit:** `retry_cnt` and the timeout counter reset for every new flit.
- **Flit sequence:** a packet is always head, then (len−1) body flits, then one tail. For len = 1 that is head then tail.
- **Combinational outputs:** `flit_valid`, `pkt_ready` and `word_ready` are decoded from state; `pkt_ready` is forced 0 while `reset` is high.
- **Registered outputs:** `pkt_done` and `err` are registered pulses.

## Timing
- **Reset:**
  - State → `IDLE`.
  - `flit_valid`, `word_ready`, `pkt_done`, `err` = 0.
  - `flit_data`, all counters = 0.
  - `pkt_ready` = 0 during the reset cycle, 1 from the first cycle after.
  - Reset mid-packet abandons the packet with no `err` pulse.
- **Best-case cycle sequence** (`router_available` = 1, ack on the first `WAIT_ACK` cycle):
  - Accept at cycle 0.
  - Head `flit_valid` in cycles 1–2.
  - `FETCH` at cycle 3.
  - Body/tail `flit_valid` in cycles 4–5.
  - Each further payload word costs 3 cycles.
  - `pkt_done` is high one cycle after the tail ack, coincident with `pkt_ready` = 1.
- **Back-to-back packets:** a new descriptor may be accepted in the same cycle `pkt_done` is high.
- **Ack timeout:** with `ACK_TIMEOUT` = 16, the 16th consecutive unacked `WAIT_ACK` cycle triggers `BACKOFF` on the next edge.
- **Abort timing:** the worst-case abort comes after (`MAX_RETRY`+1) attempts; `err` is high the cycle after the final timeout.
- **Flit stability:** `flit_data` changes only on a transition into `SEND` (from `IDLE` or `FETCH`), never while `flit_valid` = 1.

## Test plan
- **Single packet:** dest = 5, len = 3, words A/B/C, ack after 1 cycle → flits {01, dest 5 / len 3}, {10, A}, {10, B}, {11, C}; `pkt_done` pulses once; exactly 3 `word_ready` handshakes.
- **Router backpressure:** `router_available` low for 4 cycles in `SEND` → `flit_valid` stays 0 for those cycles, then rises with unchanged `flit_data`.
- **Timeout recovery:** ack withheld for 16 cycles on a body flit → 1-cycle `flit_valid` drop, identical flit re-presented; ack then completes the packet with no `err`.
- **Retry exhaustion:** no ack ever → 4 attempts of the head flit, `err` pulse, return to `IDLE`, zero `word_ready` handshakes.
- **Bad length:** `pkt_len` = 0, then `pkt_len` = 9 → `err` pulse each time, no `flit_valid`, `pkt_ready` stays 1.
- **Reset mid-packet:** reset asserted during `WAIT_ACK` of the 2nd flit → all outputs at reset values on the next cycle; a following len = 1 packet transfers correctly.
